// File: rtl/comp_wta_pkg.sv
// Shared types and helpers for the sequential winner-take-all comparator.
package comp_wta_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Smallest r with 2**r >= v; used to size the channel counter.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/comp_upd.sv
// Single-candidate running-best update: lowest index wins ties, zero never wins.
module comp_upd #(
  parameter int unsigned p_width = 19,
  parameter int unsigned p_iw    = 3
) (
  input  logic [p_width-1:0] cand,
  input  logic [p_width-1:0] best,
  input  logic               found,
  input  logic [p_width-1:0] thr,
  input  logic [p_iw-1:0]    cnt,
  input  logic [p_iw-1:0]    best_idx,
  output logic [p_width-1:0] nxt_best,
  output logic [p_iw-1:0]    nxt_idx,
  output logic               nxt_found
);

  logic take;

  always_comb begin
    take      = (cand >= thr) && ((cand > best) || !found) && (cand != '0);
    nxt_best  = take ? cand : best;
    nxt_idx   = take ? cnt  : best_idx;
    nxt_found = take | found;
  end

endmodule

// File: rtl/comp_wta_seq.sv
// Sequential winner-take-all comparator: snapshots p_n channels on start,
// scans one channel per clock and registers the winner on the final edge.
module comp_wta_seq
  import comp_wta_pkg::*;
#(
  parameter  int unsigned p_width = 19,
  parameter  int unsigned p_n     = 8,
  localparam int unsigned p_iw    = clog2(p_n)
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_start,
  input  logic [p_n*p_width-1:0] i_data,
  input  logic [p_width-1:0]     i_thresh,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_valid,
  output logic [p_width-1:0]     o_result,
  output logic [p_n-1:0]         o_index,
  output logic [p_iw-1:0]        o_index_bin
);

  localparam logic [p_iw-1:0] last_cnt = p_iw'(p_n - 1);
  localparam logic [p_n-1:0]  one_lsb  = p_n'(1);

  state_t             state;
  logic [p_width-1:0] snap [p_n];
  logic [p_width-1:0] thr;
  logic [p_iw-1:0]    cnt;
  logic [p_width-1:0] best;
  logic [p_iw-1:0]    best_idx;
  logic               found;

  logic [p_width-1:0] cand;
  logic [p_width-1:0] upd_best;
  logic [p_iw-1:0]    upd_idx;
  logic               upd_found;

  assign cand = snap[cnt];

  // The same updater serves every scan edge, including the final merge of
  // channel p_n-1 into the registered outputs.
  comp_upd #(
    .p_width (p_width),
    .p_iw    (p_iw)
  ) u_upd (
    .cand      (cand),
    .best      (best),
    .found     (found),
    .thr       (thr),
    .cnt       (cnt),
    .best_idx  (best_idx),
    .nxt_best  (upd_best),
    .nxt_idx   (upd_idx),
    .nxt_found (upd_found)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state <= S_IDLE;
      for (int unsigned k = 0; k < p_n; k++) snap[k] <= '0;
      thr         <= '0;
      cnt         <= '0;
      best        <= '0;
      best_idx    <= '0;
      found       <= 1'b0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_valid     <= 1'b0;
      o_result    <= '0;
      o_index     <= '0;
      o_index_bin <= '0;
    end else begin
      o_done <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (i_start) begin
            for (int unsigned k = 0; k < p_n; k++) snap[k] <= i_data[k*p_width +: p_width];
            thr      <= i_thresh;
            cnt      <= '0;
            best     <= '0;
            best_idx <= '0;
            found    <= 1'b0;
            o_busy   <= 1'b1;
            state    <= S_SCAN;
          end
        end
        S_SCAN: begin
          best     <= upd_best;
          best_idx <= upd_idx;
          found    <= upd_found;
          if (cnt == last_cnt) begin
            o_result    <= upd_best;
            o_index_bin <= upd_idx;
            o_index     <= upd_found ? (one_lsb << upd_idx) : '0;
            o_valid     <= upd_found;
            o_done      <= 1'b1;
            o_busy      <= 1'b0;
            state       <= S_DONE;
          end else begin
            cnt <= cnt + p_iw'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/comp_wta_seq.md
Name: comp_wta_seq

Overview:
- Parametrised, sequential winner-take-all comparator for the SNN output layer; successor to the fixed 4-input combinational max comparator.
- Snapshots p_n unsigned channel values plus a threshold on a start strobe, then scans one channel per clock. Reports the maximum value, its one-hot index, its binary index and a valid flag.
- Sits between the neuron membrane-potential/spike-count registers and the classification/readout logic.

Parameters:
- p_width, 19, bit width of each channel value and of the threshold.
- p_n, 8, number of channels; legal range 2..64.
- p_iw, $clog2(p_n), binary index width; derived, not overridden.

Ports:
- i_clk  in  1  system clock, rising edge.
- i_rst_n  in  1  synchronous reset, active-low.
- i_start  in  1  start strobe; sampled only in IDLE or DONE.
- i_data  in  p_n*p_width  flattened channel values; channel k occupies bits [k*p_width +: p_width].
- i_thresh  in  p_width  minimum value a winner must reach; latched with i_data.
- o_busy  out  1  high while scanning.
- o_done  out  1  single-cycle pulse when results update.
- o_valid  out  1  a winner exists (held).
- o_result  out  p_width  winning value, or 0 if none (held).
- o_index  out  p_n  one-hot winner index, or 0 if none (held).
- o_index_bin  out  p_iw  binary winner index, or 0 if none (held).

Behaviour:
- Clock and reset: one clock, i_clk. Reset is synchronous and active-low on i_rst_n.
- Reset: state=IDLE; all outputs 0; snapshot, threshold, counter and running-best registers cleared. Reset during SCAN aborts the scan. No o_done is issued for the aborted scan.
- States:
  - IDLE: i_start=1 -> SCAN.
  - SCAN: counter reaches p_n-1 -> DONE.
  - DONE: i_start=1 -> SCAN; otherwise stay in DONE.
- Start edge (i_start=1 in IDLE/DONE):
  - snapshot<=i_data, thr<=i_thresh, cnt<=0, best<=0, best_idx<=0, found<=0, o_busy<=1.
  - Held outputs keep their previous values until the new result lands.
- Per SCAN edge, candidate v = snapshot channel cnt:
  - If (v >= thr) and (v > best or found==0) and v != 0, then best<=v, best_idx<=cnt, found<=1.
  - Otherwise no change. Then cnt<=cnt+1.
- Tie rule: the strict comparison keeps the lowest index among equal maxima, matching the existing comparator's preference for the earlier input.
- Zero rule: a zero value never wins. All-zero input gives o_valid=0, o_result=0, o_index=0, o_index_bin=0.
- Threshold of 0 makes any nonzero maximum valid.
- Final SCAN edge (cnt==p_n-1):
  - The comparison for channel p_n-1 is included.
  - o_result, o_index_bin, o_index (=1<<idx), o_valid are registered from the final best, found and best_idx values, combinationally merged with channel p_n-1.
  - o_done<=1, o_busy<=0, state<=DONE.
- Latency: start sampled at edge 0; results and o_done visible after edge p_n, i.e. p_n cycles.
- Throughput: a new start is accepted in the DONE cycle, giving back-to-back scans every p_n+1 cycles.
- o_done: high exactly one cycle, then 0, even if the FSM remains in DONE.
- i_start during SCAN: ignored, no queuing.
- i_data/i_thresh changes during SCAN: no effect (snapshot).
- Counter: p_iw bits, does not wrap inside a scan. When p_n is not a power of two, the terminal compare is cnt==p_n-1.
- Arithmetic: all comparisons are unsigned and p_width wide; no truncation.

Decomposition:
- Package comp_wta_pkg:
  - state encoding constants S_IDLE=2'd0, S_SCAN=2'd1, S_DONE=2'd2;
  - a clog2 function for p_iw.
- Sub-module comp_upd (combinational): inputs candidate, best, found, thr, cnt, best_idx; outputs next best, best_idx, found. The final-edge merge uses the same sub-module instance.
- Top level: FSM, snapshot register, counter, channel mux, output registers.

Test Plan (p_n=8, p_width=19):
- Reset mid-scan: assert i_rst_n=0 at scan cycle 3 -> next cycle state IDLE, all outputs 0, no o_done.
- Distinct values, i_data ch0..7 = {5,900,17,3,900,12,0,899}, thr=0, start -> o_done 8 cycles after start edge; o_result=900, o_index=8'b0000_0010, o_index_bin=1, o_valid=1 (tie resolved to ch1).
- All zero, i_data all 0, thr=0 -> o_valid=0, o_result=0, o_index=0, o_index_bin=0, o_done pulses once.
- Threshold, ch5=100 max, others <=50, thr=101 -> o_valid=0, o_result=0; rerun with thr=100 -> o_valid=1, o_index_bin=5, o_result=100.
- Full scale, ch7=19'h7FFFF, ch0=19'h7FFFE -> o_result=19'h7FFFF, o_index=8'b1000_0000, o_index_bin=7.
- Back-to-back with mid-scan noise: start in DONE cycle with new data while toggling i_data and i_start during SCAN -> result reflects the snapshot only; o_busy high for exactly 8 cycles; each scan gives one o_done.
